// File: rtl/reorder_pkg.sv
// Shared widths and types for the reorder buffer slice.
// Module-level DEPTH overrides are re-derived locally; these types describe the default build.
package reorder_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;
    localparam int TAG_W         = $clog2(DEFAULT_DEPTH);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   ptr_t;
    typedef logic [TAG_W:0]   cnt_t;

endpackage

// File: rtl/mdl_memory.sv
// Dual-port register-file memory with async clear and a same-cycle write-to-read bypass.
// data_out is forced to zero whenever vld_out is low.
module mdl_memory #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    input  logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // A write landing on the read address is forwarded so the reader sees it this cycle.
    always_comb begin
        data_out = '0;
        if (vld_out) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                data_out = wr_data;
            end else begin
                data_out = mem_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/reorder_ctrl.sv
// In-order drain controller: hands out tags, absorbs out-of-order completions, drains in tag order.
// Define REORDER_CHK_EN to drop illegal completions, raise a sticky err and enable assertions.
module reorder_ctrl
    import reorder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int TW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TW-1:0]    alloc_tag,
    input  logic             cpl_vld,
    input  logic [TW-1:0]    cpl_tag,
    input  logic [WIDTH-1:0] cpl_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [TW-1:0]    out_tag,
    output logic [WIDTH-1:0] out_data,
    output logic [TW:0]      count,
    output logic             err
);

    typedef logic [TW-1:0] idx_t;
    typedef logic [TW:0]   pos_t;

    pos_t             head_q, head_d;
    pos_t             tail_q, tail_d;
    logic [DEPTH-1:0] done_q, done_d;

    idx_t head_idx;
    idx_t tail_idx;
    logic full;
    logic empty;
    logic cpl_ok;
    logic drain;

    assign head_idx = head_q[TW-1:0];
    assign tail_idx = tail_q[TW-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TW] != tail_q[TW]);
    assign empty    = (head_q == tail_q);
    assign count    = tail_q - head_q;

    assign alloc_gnt = alloc_req & ~full;
    assign alloc_tag = tail_idx;
    assign out_tag   = head_idx;

`ifdef REORDER_CHK_EN
    localparam pos_t DEPTH_CNT = pos_t'(DEPTH);

    idx_t cpl_off;
    logic cpl_in_window;
    logic err_q, err_d;

    // A tag is live when its distance from head is below the occupancy.
    assign cpl_off       = cpl_tag - head_idx;
    assign cpl_in_window = ({1'b0, cpl_off} < count);
    assign cpl_ok        = cpl_vld & cpl_in_window & ~done_q[cpl_tag];
    assign err_d         = err_q | (cpl_vld & ~cpl_ok);
    assign err           = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    a_no_vld_when_empty : assert property (@(posedge clk) disable iff (rst) empty |-> !out_vld);
    a_count_bound       : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
`else
    assign cpl_ok = cpl_vld;
    assign err    = 1'b0;
`endif

    assign out_vld = ~empty & (done_q[head_idx] | (cpl_ok & (cpl_tag == head_idx)));
    assign drain   = out_vld & out_rdy;

    // Completion sets first so a same-cycle drain of the head tag leaves the bit clear.
    always_comb begin
        done_d = done_q;
        if (cpl_ok) begin
            done_d[cpl_tag] = 1'b1;
        end
        if (drain) begin
            done_d[head_idx] = 1'b0;
        end
        head_d = head_q + pos_t'(drain);
        tail_d = tail_q + pos_t'(alloc_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            done_q <= done_d;
        end
    end

    mdl_memory #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cpl_ok),
        .wr_addr  (cpl_tag),
        .wr_data  (cpl_data),
        .rd_addr  (head_idx),
        .vld_out  (out_vld),
        .data_out (out_data)
    );

endmodule

// File: tb/tb_reorder_ctrl.sv
// Directed self-checking bench for reorder_ctrl at DEPTH=4, WIDTH=8.
// Covers REORDER_CHK_EN behaviour when the macro is defined, default behaviour otherwise.
module tb_reorder_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int TW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             alloc_req;
    logic             alloc_gnt;
    logic [TW-1:0]    alloc_tag;
    logic             cpl_vld;
    logic [TW-1:0]    cpl_tag;
    logic [WIDTH-1:0] cpl_data;
    logic             out_vld;
    logic             out_rdy;
    logic [TW-1:0]    out_tag;
    logic [WIDTH-1:0] out_data;
    logic [TW:0]      count;
    logic             err;

    int errors = 0;
    int checks = 0;

    reorder_ctrl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_tag (alloc_tag),
        .cpl_vld   (cpl_vld),
        .cpl_tag   (cpl_tag),
        .cpl_data  (cpl_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        alloc_req = 1'b0;
        cpl_vld   = 1'b0;
        cpl_tag   = '0;
        cpl_data  = '0;
        out_rdy   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            next_cycle();
        end
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b0 || out_vld !== 1'b0 || out_data !== 8'h00 ||
            count !== 3'd0 || alloc_tag !== 2'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: gnt=%b vld=%b data=%h count=%0d tag=%0d err=%b, required 0 0 00 0 0 0",
                     alloc_gnt, out_vld, out_data, count, alloc_tag, err);
        end
        next_cycle();
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            @(negedge clk);
            checks++;
            if (alloc_gnt !== 1'b1 || alloc_tag !== TW'(i)) begin
                errors++;
                $display("[TB] FAIL in_order_alloc%0d: gnt=%b tag=%0d, required 1 %0d", i, alloc_gnt, alloc_tag, i);
            end
            next_cycle();
        end
        alloc_req = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL in_order_count_full: count=%0d, required 4", count);
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            cpl_vld  = 1'b1;
            cpl_tag  = TW'(i);
            cpl_data = 8'h10 + 8'(i);
            out_rdy  = 1'b1;
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out_tag !== TW'(i) || out_data !== 8'h10 + 8'(i)) begin
                errors++;
                $display("[TB] FAIL in_order_drain%0d: vld=%b tag=%0d data=%h, required 1 %0d %h",
                         i, out_vld, out_tag, out_data, i, 8'h10 + 8'(i));
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_order_empty: count=%0d vld=%b, required 0 0", count, out_vld);
        end
        next_cycle();
    endtask

    task automatic test_reverse();
        logic [7:0] rev_data [4];
        rev_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_reset();
        alloc_n(4);
        for (int t = 3; t >= 1; t--) begin
            cpl_vld  = 1'b1;
            cpl_tag  = TW'(t);
            cpl_data = rev_data[t];
            out_rdy  = 1'b1;
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reverse_hold_tag%0d: vld=%b, required 0", t, out_vld);
            end
            next_cycle();
        end
        cpl_tag  = 2'd0;
        cpl_data = 8'hA0;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'hA0 || out_tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reverse_bypass: vld=%b tag=%0d data=%h, required 1 0 a0", out_vld, out_tag, out_data);
        end
        next_cycle();
        cpl_vld = 1'b0;
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out_tag !== TW'(t) || out_data !== rev_data[t]) begin
                errors++;
                $display("[TB] FAIL reverse_drain%0d: vld=%b tag=%0d data=%h, required 1 %0d %h",
                         t, out_vld, out_tag, out_data, t, rev_data[t]);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reverse_count: count=%0d, required 0", count);
        end
        next_cycle();
    endtask

    task automatic test_full();
        do_reset();
        alloc_n(4);
        alloc_req = 1'b1;
        out_rdy   = 1'b0;
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL full_block: gnt=%b count=%0d, required 0 4", alloc_gnt, count);
        end
        next_cycle();
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd0;
        cpl_data = 8'h5A;
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b0 || out_vld !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL full_backpressure: gnt=%b vld=%b count=%0d, required 0 1 4", alloc_gnt, out_vld, count);
        end
        next_cycle();
        cpl_vld   = 1'b0;
        alloc_req = 1'b0;
        out_rdy   = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL full_drain: vld=%b data=%h, required 1 5a", out_vld, out_data);
        end
        next_cycle();
        out_rdy   = 1'b0;
        alloc_req = 1'b1;
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd0 || count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL full_wrap_alloc: gnt=%b tag=%0d count=%0d, required 1 0 3", alloc_gnt, alloc_tag, count);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || alloc_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_wrap_refull: count=%0d gnt=%b, required 4 0", count, alloc_gnt);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        alloc_n(2);
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd0;
        cpl_data = 8'h3C;
        next_cycle();
        cpl_vld   = 1'b0;
        alloc_req = 1'b1;
        out_rdy   = 1'b1;
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd2 || out_vld !== 1'b1 || out_data !== 8'h3C || count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL simul_cycle: gnt=%b tag=%0d vld=%b data=%h count=%0d, required 1 2 1 3c 2",
                     alloc_gnt, alloc_tag, out_vld, out_data, count);
        end
        next_cycle();
        alloc_req = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || out_tag !== 2'd1 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_after: count=%0d head=%0d vld=%b, required 2 1 0", count, out_tag, out_vld);
        end
        next_cycle();
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd1;
        cpl_data = 8'h4D;
        next_cycle();
        cpl_vld = 1'b0;
        cpl_tag = 2'd0;
        out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd1 || out_vld !== 1'b0 || out_tag !== 2'd2) begin
            errors++;
            $display("[TB] FAIL simul_head_clear: count=%0d vld=%b head=%0d, required 1 0 2", count, out_vld, out_tag);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        alloc_n(3);
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd0;
        cpl_data = 8'h66;
        next_cycle();
        cpl_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0 || count !== 3'd0 || alloc_tag !== 2'd0 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midflight_reset: vld=%b count=%0d tag=%0d data=%h, required 0 0 0 00",
                     out_vld, count, alloc_tag, out_data);
        end
        next_cycle();
        rst       = 1'b0;
        alloc_req = 1'b1;
        @(negedge clk);
        checks++;
        if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd0 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_realloc: gnt=%b tag=%0d vld=%b, required 1 0 0", alloc_gnt, alloc_tag, out_vld);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_bad_completion();
        logic       exp_err;
        logic       exp_vld2;
        logic [7:0] exp_data2;
`ifdef REORDER_CHK_EN
        exp_err   = 1'b1;
        exp_vld2  = 1'b0;
        exp_data2 = 8'h00;
`else
        exp_err   = 1'b0;
        exp_vld2  = 1'b1;
        exp_data2 = 8'h55;
`endif
        do_reset();
        alloc_n(1);
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd2;
        cpl_data = 8'h55;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL badcpl_no_drain: vld=%b count=%0d, required 0 1", out_vld, count);
        end
        next_cycle();
        cpl_tag  = 2'd0;
        cpl_data = 8'h77;
        out_rdy  = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== exp_err || out_vld !== 1'b1 || out_data !== 8'h77) begin
            errors++;
            $display("[TB] FAIL badcpl_own_data: err=%b vld=%b data=%h, required %b 1 77", err, out_vld, out_data, exp_err);
        end
        next_cycle();
        cpl_vld = 1'b0;
        out_rdy = 1'b0;
        alloc_n(2);
        cpl_vld  = 1'b1;
        cpl_tag  = 2'd1;
        cpl_data = 8'h88;
        out_rdy  = 1'b1;
        next_cycle();
        cpl_vld = 1'b0;
        out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vld !== exp_vld2 || out_data !== exp_data2 || err !== exp_err || out_tag !== 2'd2) begin
            errors++;
            $display("[TB] FAIL badcpl_tag2_state: vld=%b data=%h err=%b head=%0d, required %b %h %b 2",
                     out_vld, out_data, err, out_tag, exp_vld2, exp_data2, exp_err);
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_reverse();
        test_full();
        test_simultaneous();
        test_reset_midflight();
        test_bad_completion();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_ctrl.md
Name: reorder_ctrl

Overview:
In-order drain controller for the reorder memory path.
- Hands out sequential tags to requesters.
- Accepts completions carrying those tags in any order and stores their data in a DEPTH-entry dual-port memory.
- Releases data strictly in tag-allocation order over a valid/ready output.
- Drives the memory's write side (completions) and read side (drain); together they form one reorder buffer.

Parameters:
DEPTH, 16, number of tags and entries; power of two, >= 2
WIDTH, 8, completion data width in bits

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
alloc_req  in  1  requester wants a tag
alloc_gnt  out  1  tag granted this cycle
alloc_tag  out  $clog2(DEPTH)  granted tag (= tail pointer)
cpl_vld  in  1  completion valid
cpl_tag  in  $clog2(DEPTH)  completion tag
cpl_data  in  WIDTH  completion payload
out_vld  out  1  head entry ready to drain
out_rdy  in  1  downstream accepts
out_tag  out  $clog2(DEPTH)  tag being drained (= head pointer)
out_data  out  WIDTH  drained payload
count  out  $clog2(DEPTH)+1  allocated, not yet drained entries
err  out  1  sticky protocol error (REORDER_CHK_EN only)

Behaviour:
- State:
  - head and tail pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - done[DEPTH] completion bitmap.
- Reset (async, rst=1): head=tail=0, done=0, err=0, memory cleared. Consequently alloc_gnt=0, out_vld=0, out_data=0, count=0.
- full = (head/tail index equal AND wrap bits differ). empty = (head==tail).
- Allocation:
  - alloc_gnt = alloc_req & ~full. Combinational, zero latency.
  - alloc_tag = tail index whenever not full.
  - On grant, tail increments at the clock edge.
  - full is evaluated before any same-cycle drain; no alloc-through-drain bypass.
- Completion:
  - On cpl_vld, memory write at wr_addr=cpl_tag; done[cpl_tag] sets at the edge.
- Drain:
  - out_vld = ~empty & (done[head] | (cpl_vld & cpl_tag==head)).
  - A same-cycle completion to the head tag drains with 0-cycle latency, using the memory's write-to-read bypass.
  - Memory rd_addr = head index, vld_out = out_vld; out_data = memory data_out. out_data is 0 when out_vld=0.
  - On out_vld & out_rdy: done[head] clears and head increments.
  - out_vld may deassert only after acceptance.
- Simultaneous events:
  - Alloc plus drain in one cycle: count unchanged, both pointers advance.
  - A completion setting done[x] and a drain clearing done[head] with x≠head are independent.
  - With x==head and the drain accepted, the bit ends 0.
- Wrap: pointers roll over modulo 2*DEPTH; tag = low bits.
- count = tail - head (full width). Its range is 0..DEPTH.
- Reset asserted mid-operation: all in-flight tags are discarded immediately and no output is produced until a new allocation and completion occur.

Optional Feature:
Macro REORDER_CHK_EN.
- Defined:
  - A completion whose tag is not allocated (outside [head,tail)), or whose done bit is already set, is dropped. No memory write and no done update.
  - err sets and stays set until rst.
  - Formal asserts are enabled: out_vld never rises when empty; count <= DEPTH.
- Undefined:
  - Completions are written unconditionally.
  - err is tied 0 and no check logic is compiled.

Decomposition:
- Package reorder_pkg holds:
  - tag_t, ptr_t (tag plus wrap bit), cnt_t typedefs, parameterised on DEPTH.
  - A localparam TAG_W = $clog2(DEPTH).
- One sub-module: storage instantiated as the team's mdl_memory (DEPTH/WIDTH passed through). Its wr/rd bypass supplies the 0-latency head drain.
- Pointer, bitmap and check logic stay in reorder_ctrl.

Test Plan:
All scenarios use DEPTH=4, WIDTH=8.
- In-order:
  - Stimulus: alloc 4 tags (0..3), then complete 0..3 with data 0x10..0x13; out_rdy=1.
  - Required: out_data 0x10,0x11,0x12,0x13 on tags 0..3; count returns to 0.
- Reverse order:
  - Stimulus: alloc 4, complete tags 3,2,1 (data 0xA3,0xA2,0xA1); out_vld must stay 0. Then complete tag 0 with 0xA0.
  - Required: out_vld=1 in the tag-0 completion cycle itself (bypass); then 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
- Full/backpressure:
  - Stimulus: alloc 4 (count=4), then alloc_req=1 with out_rdy=0.
  - Required: alloc_gnt=0 and count stays 4. One drain then frees slot 0; the next alloc gets tag 0 with the wrap bit flipped.
- Simultaneous:
  - Stimulus: with count=2 and head done, assert alloc_req and out_rdy in the same cycle.
  - Required: grant and drain both occur; count stays 2.
- Reset mid-flight:
  - Stimulus: allocate 3, complete 1, assert rst asynchronously between edges.
  - Required: out_vld=0, count=0 and alloc_tag=0 immediately; post-reset alloc returns tag 0.
- REORDER_CHK_EN:
  - Stimulus: completion to unallocated tag 2 while count=1.
  - Required: err=1 sticky, no memory write, tag 0 still drains with its own data.
